// File: rtl/rx_os_lane_counters_pkg.sv
// Shared definitions for the RX ordered-set lane counter bank: substate codes,
// OS type codes, lane states and the substate-to-expected-type mapping.
package rx_os_lane_counters_pkg;

  localparam logic [3:0] SS_DETECT_QUIET         = 4'd0;
  localparam logic [3:0] SS_DETECT_ACTIVE        = 4'd1;
  localparam logic [3:0] SS_POLLING_ACTIVE       = 4'd2;
  localparam logic [3:0] SS_POLLING_CONFIG       = 4'd3;
  localparam logic [3:0] SS_CFG_LINKWIDTH_START  = 4'd4;
  localparam logic [3:0] SS_CFG_LINKWIDTH_ACCEPT = 4'd5;
  localparam logic [3:0] SS_CFG_LANENUM_WAIT     = 4'd6;
  localparam logic [3:0] SS_CFG_LANENUM_ACCEPT   = 4'd7;
  localparam logic [3:0] SS_CFG_COMPLETE         = 4'd8;
  localparam logic [3:0] SS_CFG_IDLE             = 4'd9;

  localparam logic [1:0] OS_OTHER = 2'b00;
  localparam logic [1:0] OS_TS1   = 2'b01;
  localparam logic [1:0] OS_TS2   = 2'b10;
  localparam logic [1:0] OS_IDLE  = 2'b11;

  // Non-NONE encodings deliberately equal the matching OS type codes.
  typedef enum logic [1:0] {
    EXP_NONE = 2'b00,
    EXP_TS1  = 2'b01,
    EXP_TS2  = 2'b10,
    EXP_IDLE = 2'b11
  } exp_type_t;

  typedef enum logic [1:0] {
    LANE_IDLE  = 2'b00,
    LANE_COUNT = 2'b01,
    LANE_MET   = 2'b10
  } lane_state_t;

  function automatic exp_type_t exp_of_substate(input logic [3:0] ss);
    exp_type_t e;
    case (ss)
      SS_POLLING_ACTIVE, SS_CFG_LINKWIDTH_START, SS_CFG_LINKWIDTH_ACCEPT:
        e = EXP_TS1;
      SS_POLLING_CONFIG, SS_CFG_LANENUM_WAIT, SS_CFG_LANENUM_ACCEPT, SS_CFG_COMPLETE:
        e = EXP_TS2;
      SS_CFG_IDLE:
        e = EXP_IDLE;
      default:
        e = EXP_NONE;
    endcase
    return e;
  endfunction

  function automatic logic os_matches(input exp_type_t e, input logic [1:0] t);
    return (e != EXP_NONE) && (t == 2'(e));
  endfunction

endpackage

// File: rtl/rx_os_lane_counter.sv
// One lane slice: IDLE_L/COUNT/MET state machine, saturating consecutive-OS
// counter and registered comparator. Optional sticky under RX_OS_MISMATCH_STATS_EN.
module rx_os_lane_counter
  import rx_os_lane_counters_pkg::*;
#(
  parameter int CNTW = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sub_change,
  input  logic       enable,
  input  logic       active,
  input  logic       os_valid,
  input  logic [1:0] os_type,
  input  logic [1:0] exp_type,
  input  logic [4:0] threshold,
  output logic       comparator
`ifdef RX_OS_MISMATCH_STATS_EN
  ,
  output logic       mismatch_sticky
`endif
);

  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  lane_state_t     state_r;
  lane_state_t     state_nxt;
  logic [CNTW-1:0] cnt_r;
  logic [CNTW-1:0] cnt_nxt;
  exp_type_t       exp_s;
  logic            match_s;
  logic            mismatch_s;

  assign exp_s      = exp_type_t'(exp_type);
  assign match_s    = os_matches(exp_s, os_type);
  assign mismatch_s = (exp_s != EXP_NONE) && !match_s;

  // Next-state and next-count; earlier branches take priority.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    if (sub_change) begin
      cnt_nxt   = CNT_ZERO;
      state_nxt = (enable && active) ? LANE_COUNT : LANE_IDLE;
    end else if (!enable) begin
      cnt_nxt   = CNT_ZERO;
      state_nxt = LANE_IDLE;
    end else if (!active) begin
      cnt_nxt   = CNT_ZERO;
      state_nxt = LANE_IDLE;
    end else begin
      case (state_r)
        LANE_IDLE: begin
          cnt_nxt = CNT_ZERO;
        end
        LANE_COUNT, LANE_MET: begin
          if (exp_s == EXP_NONE) begin
            cnt_nxt = CNT_ZERO;
          end else if (os_valid) begin
            if (match_s) begin
              cnt_nxt = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
            end else begin
              cnt_nxt = CNT_ZERO;
            end
          end else begin
            cnt_nxt = cnt_r;
          end
        end
        default: begin
          cnt_nxt = CNT_ZERO;
        end
      endcase
      // Threshold is re-evaluated every cycle, so a threshold change moves MET lanes too.
      state_nxt = (32'(cnt_nxt) >= 32'(threshold)) ? LANE_MET : LANE_COUNT;
    end
  end

  // Lane state, counter and comparator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= LANE_IDLE;
      cnt_r      <= CNT_ZERO;
      comparator <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      comparator <= (state_nxt == LANE_MET);
    end
  end

`ifdef RX_OS_MISMATCH_STATS_EN
  // Sticky record of any OS that broke an expected-type run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch_sticky <= 1'b0;
    end else if (sub_change || !enable) begin
      mismatch_sticky <= 1'b0;
    end else if (os_valid && mismatch_s) begin
      mismatch_sticky <= 1'b1;
    end else begin
      mismatch_sticky <= mismatch_sticky;
    end
  end
`endif

endmodule

// File: rtl/rx_os_lane_counters.sv
// Per-lane consecutive ordered-set counter bank feeding the RX LTSSM comparators.
// Optional per-lane mismatch sticky output enabled by RX_OS_MISMATCH_STATS_EN.
module rx_os_lane_counters
  import rx_os_lane_counters_pkg::*;
#(
  parameter int MAXLANES = 16,
  parameter int CNTW     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            substate,
  input  logic [4:0]            numberOfDetectedLanes,
  input  logic [4:0]            comparatorsCount,
  input  logic [MAXLANES-1:0]   resetOsCheckers,
  input  logic [MAXLANES-1:0]   osValid,
  input  logic [2*MAXLANES-1:0] osType,
  output logic [MAXLANES-1:0]   countersComparators
`ifdef RX_OS_MISMATCH_STATS_EN
  ,
  output logic [MAXLANES-1:0]   osMismatchSticky
`endif
);

  exp_type_t             exp_r;
  logic [3:0]            last_r;
  logic                  sub_change_s;
  logic [MAXLANES-1:0]   lane_active_s;

  // 4'hF after reset guarantees the first real substate is seen as a change.
  assign sub_change_s = (substate != last_r);

  // Expected OS type tracks the substate, updated only on a change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_r  <= EXP_NONE;
      last_r <= 4'hF;
    end else if (sub_change_s) begin
      exp_r  <= exp_of_substate(substate);
      last_r <= substate;
    end else begin
      exp_r  <= exp_r;
      last_r <= last_r;
    end
  end

  for (genvar i = 0; i < MAXLANES; i++) begin : g_lane
    assign lane_active_s[i] = (32'(numberOfDetectedLanes) > 32'(i));

    rx_os_lane_counter #(
      .CNTW(CNTW)
    ) u_lane (
      .clk            (clk),
      .reset          (reset),
      .sub_change     (sub_change_s),
      .enable         (resetOsCheckers[i]),
      .active         (lane_active_s[i]),
      .os_valid       (osValid[i]),
      .os_type        (osType[2*i +: 2]),
      .exp_type       (2'(exp_r)),
      .threshold      (comparatorsCount),
      .comparator     (countersComparators[i])
`ifdef RX_OS_MISMATCH_STATS_EN
      ,
      .mismatch_sticky(osMismatchSticky[i])
`endif
    );
  end

endmodule
